// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction prefetch queue:
//   FETCH_DEPTH    : default queue depth in bytes (power of two)
//   FETCH_MAX_ILEN : default longest legal instruction in bytes
//   fetch_state_e  : fetch FSM state encoding (IDLE / REQ / HALT)
//   fetch_ptr_w()  : queue pointer width for a given depth
// -----------------------------------------------------------------------------
package fetch_pkg;

   localparam int FETCH_DEPTH    = 8;
   localparam int FETCH_MAX_ILEN = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_e;

   function automatic int fetch_ptr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/fetch_byteq.sv
// -----------------------------------------------------------------------------
// fetch_byteq
// Circular byte queue with single-byte push, multi-byte pop and flush.
// Ports:
//   clk2, reset  : clock (rising edge), asynchronous active-high reset
//   i_push       : write i_wdata at the tail this cycle
//   i_wdata      : byte to push
//   i_pop_len    : number of bytes to retire from the head (0 = none)
//   i_flush      : empty the queue (overrides push/pop)
//   o_peek       : four oldest bytes, oldest in [31:24]; empty lanes read 0
//   o_count      : number of bytes currently held
// The caller guarantees no push when full and no pop beyond o_count.
// -----------------------------------------------------------------------------
module fetch_byteq
   import fetch_pkg::*;
#(
   parameter int DEPTH = FETCH_DEPTH,
   parameter int PTR_W = fetch_ptr_w(FETCH_DEPTH)
) (
   input  logic             clk2,
   input  logic             reset,
   input  logic             i_push,
   input  logic [7:0]       i_wdata,
   input  logic [3:0]       i_pop_len,
   input  logic             i_flush,
   output logic [31:0]      o_peek,
   output logic [PTR_W:0]   o_count
);

   localparam int CNT_W = PTR_W + 1;

   logic [7:0]       r_mem [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   // Byte storage carries no reset; unfilled lanes are masked by the count.
   always_ff @(posedge clk2) begin
      if (i_push) begin
         r_mem[r_tail] <= i_wdata;
      end
   end

   always_ff @(posedge clk2 or posedge reset) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_head  <= r_tail;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_tail <= r_tail + PTR_W'(1);
         end
         // Depth is a power of two, so truncating the sum wraps the head.
         r_head  <= r_head + PTR_W'(i_pop_len);
         r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop_len);
      end
   end

   always_comb begin
      o_peek = '0;
      for (int k = 0; k < 4; k++) begin
         if (CNT_W'(k) < r_count) begin
            o_peek[31-8*k -: 8] = r_mem[r_head + PTR_W'(k)];
         end
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction prefetch stage feeding the decoder. Fetches bytes one at a time
// from byte-wide instruction memory into a circular queue, presents a 32-bit
// window of the oldest bytes and retires the decoded instruction length.
// Redirects flush the queue and refetch from a new address.
//
// Optional feature macro: FETCH_STALL_CNT_EN
//   defined   : stall_cnt counts cycles without a valid window (outside HALT),
//               saturating at 16'hFFFF, cleared only by reset
//   undefined : stall_cnt is tied to zero
//
// Ports:
//   clk2, reset           : clock (rising edge), asynchronous active-high reset
//   mem_req/mem_addr      : byte read request and address (held until ack)
//   mem_ack/mem_rdata     : read completion and data byte
//   ope/ope_valid         : 4-byte window (oldest in [31:24]) and valid flag
//   eip                   : address of the byte in ope[31:24]
//   advance/adv_len       : retire adv_len bytes of the current instruction
//   eip_load/eip_new      : redirect to a new fetch address
//   err                   : sticky illegal-advance flag
//   stall_cnt             : starved-cycle counter
// -----------------------------------------------------------------------------
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int          DEPTH      = FETCH_DEPTH,
   parameter int          MAX_ILEN   = FETCH_MAX_ILEN,
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic        clk2,
   input  logic        reset,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata,
   output logic [31:0] ope,
   output logic        ope_valid,
   output logic [31:0] eip,
   input  logic        advance,
   input  logic [3:0]  adv_len,
   input  logic        eip_load,
   input  logic [31:0] eip_new,
   output logic        err,
   output logic [15:0] stall_cnt
);

   localparam int PTR_W = fetch_ptr_w(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fetch_state_e     r_state;
   logic [31:0]      r_fetch_ptr;
   logic [31:0]      r_eip;
   logic             r_err;

   fetch_state_e     w_state_nxt;
   logic [CNT_W-1:0] w_count;
   logic [CNT_W-1:0] w_count_nxt;
   logic [31:0]      w_peek;
   logic             w_valid;
   logic             w_halted;
   logic             w_flush;
   logic             w_adv_ok;
   logic             w_adv_bad;
   logic             w_push;
   logic [3:0]       w_pop_len;

   fetch_byteq #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_byteq (
      .clk2      (clk2),
      .reset     (reset),
      .i_push    (w_push),
      .i_wdata   (mem_rdata),
      .i_pop_len (w_pop_len),
      .i_flush   (w_flush),
      .o_peek    (w_peek),
      .o_count   (w_count)
   );

   always_comb begin
      w_valid   = (w_count >= CNT_W'(MAX_ILEN));
      w_halted  = (r_state == ST_HALT);
      // Redirect takes priority over anything the decoder does this cycle.
      w_flush   = eip_load && !w_halted;
      w_adv_bad = !w_halted && !w_flush && advance && w_valid &&
                  (adv_len > 4'(MAX_ILEN));
      w_adv_ok  = !w_halted && !w_flush && advance && w_valid &&
                  (adv_len != 4'd0) && (adv_len <= 4'(MAX_ILEN));
      // An illegal advance freezes the queue, so a coincident ack is dropped.
      w_push    = (r_state == ST_REQ) && mem_ack && !w_flush && !w_adv_bad;
      w_pop_len = w_adv_ok ? adv_len : 4'd0;
      w_count_nxt = w_flush ? '0 : (w_count + CNT_W'(w_push) - CNT_W'(w_pop_len));
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_adv_bad) begin
               w_state_nxt = ST_HALT;
            end else if (!w_flush && (w_count < CNT_W'(DEPTH))) begin
               w_state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            // A redirect drops the request for one cycle before refetching.
            if (w_flush) begin
               w_state_nxt = ST_IDLE;
            end else if (w_adv_bad) begin
               w_state_nxt = ST_HALT;
            end else if (w_push && (w_count_nxt == CNT_W'(DEPTH))) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_HALT: w_state_nxt = ST_HALT;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk2 or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_fetch_ptr <= RESET_ADDR;
         r_eip       <= RESET_ADDR;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_flush) begin
            r_fetch_ptr <= eip_new;
            r_eip       <= eip_new;
         end else begin
            if (w_push) begin
               r_fetch_ptr <= r_fetch_ptr + 32'd1;
            end
            if (w_adv_ok) begin
               r_eip <= r_eip + 32'(adv_len);
            end
         end
         if (w_adv_bad) begin
            r_err <= 1'b1;
         end
      end
   end

`ifdef FETCH_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   // Counts the cycles that end with no valid window, so the edge on which
   // the window becomes valid does not add to the total.
   always_ff @(posedge clk2 or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= '0;
      end else if ((w_state_nxt != ST_HALT) && (w_count_nxt < CNT_W'(MAX_ILEN)) &&
                   (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`else
   assign stall_cnt = '0;
`endif

   assign mem_req   = (r_state == ST_REQ);
   assign mem_addr  = r_fetch_ptr;
   assign ope       = w_peek;
   assign ope_valid = w_valid;
   assign eip       = r_eip;
   assign err       = r_err;

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
// Self-checking bench for fetch_queue: directed scenarios followed by random
// traffic, all compared against a byte-queue reference model.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

   localparam int DEPTH    = 8;
   localparam int MAX_ILEN = 6;

   logic        clk2 = 1'b0;
   logic        reset = 1'b1;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [7:0]  mem_rdata = 8'h00;
   logic [31:0] ope;
   logic        ope_valid;
   logic [31:0] eip;
   logic        advance = 1'b0;
   logic [3:0]  adv_len = 4'd0;
   logic        eip_load = 1'b0;
   logic [31:0] eip_new = 32'h0;
   logic        err;
   logic [15:0] stall_cnt;

   fetch_queue #(
      .DEPTH      (DEPTH),
      .MAX_ILEN   (MAX_ILEN),
      .RESET_ADDR (32'h0000_0000)
   ) dut (
      .clk2      (clk2),
      .reset     (reset),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .ope       (ope),
      .ope_valid (ope_valid),
      .eip       (eip),
      .advance   (advance),
      .adv_len   (adv_len),
      .eip_load  (eip_load),
      .eip_new   (eip_new),
      .err       (err),
      .stall_cnt (stall_cnt)
   );

   always #5 clk2 = ~clk2;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic [7:0]  q[$];
   logic [31:0] m_fptr;
   logic [31:0] m_eip;
   logic        m_err;
   logic        m_halt;
   logic        m_req;
   int          m_stall;

   // stimulus for the next edge
   logic        s_adv;
   logic [3:0]  s_len;
   logic        s_load;
   logic [31:0] s_new;
   int          wait_fixed;
   int          wcnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ a[31:24];
   endfunction

   function automatic logic [31:0] exp_ope();
      logic [31:0] r;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         if (k < q.size()) r[31-8*k -: 8] = q[k];
      end
      return r;
   endfunction

   task automatic model_reset();
      q.delete();
      m_fptr  = 32'h0;
      m_eip   = 32'h0;
      m_err   = 1'b0;
      m_halt  = 1'b0;
      m_req   = 1'b0;
      m_stall = 0;
   endtask

   task automatic check_all();
      chk("req",   32'(mem_req),   32'(m_req));
      chk("addr",  mem_addr,       m_fptr);
      chk("ope",   ope,            exp_ope());
      chk("vld",   32'(ope_valid), 32'(q.size() >= MAX_ILEN));
      chk("eip",   eip,            m_eip);
      chk("err",   32'(err),       32'(m_err));
      chk("stall", 32'(stall_cnt), 32'(m_stall));
   endtask

   task automatic step();
      logic ack;
      logic vld;
      logic was_req;
      int   sz0;
      if (mem_req) begin
         if (wait_fixed >= 0) ack = (wcnt >= wait_fixed);
         else                 ack = ($urandom_range(0, 2) != 0);
         if (ack) wcnt = 0;
         else     wcnt++;
         mem_rdata = mem_byte(mem_addr);
      end else begin
         ack = 1'($urandom_range(0, 1));
         mem_rdata = 8'($urandom);
         wcnt = 0;
      end
      mem_ack  = ack;
      advance  = s_adv;
      adv_len  = s_len;
      eip_load = s_load;
      eip_new  = s_new;

      vld = (q.size() >= MAX_ILEN);
      if (m_halt) begin
         m_req = 1'b0;
      end else if (s_load) begin
         q.delete();
         m_fptr = s_new;
         m_eip  = s_new;
         m_req  = 1'b0;
      end else if (s_adv && vld && (s_len > 4'(MAX_ILEN))) begin
         m_err  = 1'b1;
         m_halt = 1'b1;
         m_req  = 1'b0;
      end else begin
         sz0 = q.size();
         was_req = m_req;
         if (m_req && ack) begin
            q.push_back(mem_byte(m_fptr));
            m_fptr = m_fptr + 32'd1;
         end
         if (s_adv && vld && (s_len != 4'd0)) begin
            for (int i = 0; i < int'(s_len); i++) q.delete(0);
            m_eip = m_eip + 32'(s_len);
         end
         m_req = was_req ? (q.size() < DEPTH) : (sz0 < DEPTH);
      end
`ifdef FETCH_STALL_CNT_EN
      if (!m_halt && (q.size() < MAX_ILEN) && (m_stall != 65535)) m_stall++;
`endif

      @(posedge clk2);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      s_adv  = 1'b0;
      s_len  = 4'd0;
      s_load = 1'b0;
      s_new  = 32'h0;
      advance  = 1'b0;
      eip_load = 1'b0;
      mem_ack  = 1'b0;
      wcnt = 0;
      model_reset();
      #1;
      check_all();
      @(posedge clk2);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] snap_ope;
      logic [31:0] snap_eip;
      int r;

      wait_fixed = 0;
      do_reset();

      // zero-wait fill from address 0
      for (int c = 1; c <= 9; c++) begin
         step();
         if (c == 6) chk("fill_vld_c6", 32'(ope_valid), 32'd0);
         if (c == 7) begin
            chk("fill_vld_c7", 32'(ope_valid), 32'd1);
            chk("fill_ope",    ope, 32'h0001_0203);
            chk("fill_eip",    eip, 32'h0);
         end
         if (c == 8) chk("fill_req_c8", 32'(mem_req), 32'd1);
         if (c == 9) chk("fill_req_c9", 32'(mem_req), 32'd0);
      end

      // advance by two, then refill resumes at address 8
      s_adv = 1'b1; s_len = 4'd2;
      step();
      s_adv = 1'b0; s_len = 4'd0;
      chk("adv2_eip", eip, 32'h2);
      chk("adv2_ope", ope, 32'h0203_0405);
      step();
      chk("refill_req",  32'(mem_req), 32'd1);
      chk("refill_addr", mem_addr, 32'h8);

      // redirect with a pending request acked in the same cycle
      s_load = 1'b1; s_new = 32'h0000_1000;
      step();
      s_load = 1'b0;
      chk("redir_req0", 32'(mem_req), 32'd0);
      chk("redir_vld",  32'(ope_valid), 32'd0);
      chk("redir_eip",  eip, 32'h1000);
      step();
      chk("redir_req1", 32'(mem_req), 32'd1);
      chk("redir_addr", mem_addr, 32'h1000);
      repeat (5) step();
      chk("redir_vld_e6", 32'(ope_valid), 32'd0);
      step();
      chk("redir_vld_e7", 32'(ope_valid), 32'd1);
      chk("redir_ope",    ope, 32'h1011_1213);

      // address wrap at the top of memory
      s_load = 1'b1; s_new = 32'hFFFF_FFFE;
      step();
      s_load = 1'b0;
      step();
      chk("wrap_addr0", mem_addr, 32'hFFFF_FFFE);
      step();
      chk("wrap_addr1", mem_addr, 32'hFFFF_FFFF);
      step();
      chk("wrap_addr2", mem_addr, 32'h0000_0000);
      repeat (4) step();
      chk("wrap_vld", 32'(ope_valid), 32'd1);
      chk("wrap_ope", ope, 32'hFEFF_0001);
      s_adv = 1'b1; s_len = 4'd2;
      step();
      s_adv = 1'b0; s_len = 4'd0;
      chk("wrap_eip", eip, 32'h0);

      // illegal advance length halts the block
      repeat (3) step();
      chk("ill_pre_vld", 32'(ope_valid), 32'd1);
      snap_ope = ope;
      snap_eip = eip;
      s_adv = 1'b1; s_len = 4'd7;
      step();
      s_adv = 1'b0; s_len = 4'd0;
      chk("ill_err", 32'(err), 32'd1);
      chk("ill_eip", eip, snap_eip);
      chk("ill_ope", ope, snap_ope);
      chk("ill_req", 32'(mem_req), 32'd0);
      s_load = 1'b1; s_new = 32'h0000_5000;
      step();
      s_load = 1'b0;
      chk("halt_load_eip", eip, snap_eip);
      repeat (3) step();
      chk("halt_req", 32'(mem_req), 32'd0);

      // three wait states per byte
      wait_fixed = 3;
      do_reset();
      for (int c = 1; c <= 25; c++) begin
         step();
         if (c == 24) chk("ws_vld_c24", 32'(ope_valid), 32'd0);
         if (c == 25) begin
            chk("ws_vld_c25", 32'(ope_valid), 32'd1);
`ifdef FETCH_STALL_CNT_EN
            chk("ws_stall", 32'(stall_cnt), 32'd24);
`else
            chk("ws_stall", 32'(stall_cnt), 32'd0);
`endif
         end
      end

      // random traffic
      wait_fixed = -1;
      for (int it = 0; it < 3000; it++) begin
         s_adv = 1'($urandom_range(0, 1));
         r = int'($urandom_range(0, 99));
         if (r < 3) s_len = 4'($urandom_range(7, 15));
         else       s_len = 4'($urandom_range(0, 6));
         s_load = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 3) == 0) s_new = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
         else                           s_new = $urandom;
         step();
         if ((m_halt && ($urandom_range(0, 7) == 0)) || ($urandom_range(0, 299) == 0)) begin
            do_reset();
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
